// File: rtl/memory_access_stage.sv
// Memory stage: runs loads/stores over a req/ack data bus, formats load data,
// stalls upstream while waiting and flags misaligned/illegal/timed-out accesses.
//
// state   | meaning
// IDLE    | no bus request outstanding; mw_* register captures every cycle
// BUSY    | dmem_req_o high, waiting for dmem_ack_i or timeout
module memory_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        em_reg_write_i,
    input  logic        em_mem_read_i,
    input  logic        em_mem_write_i,
    input  logic [1:0]  em_dmem_to_reg_i,
    input  logic [2:0]  em_funct3_i,
    input  logic [4:0]  em_write_addr_reg_i,
    input  logic [31:0] em_alu_result_i,
    input  logic [31:0] em_read_data2_i,
    input  logic [31:0] em_pc_new_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        mem_stall_o,
    output logic        mw_reg_write_o,
    output logic [1:0]  mw_dmem_to_reg_o,
    output logic [4:0]  mw_write_addr_reg_o,
    output logic [31:0] mw_alu_result_o,
    output logic [31:0] mw_load_data_o,
    output logic [31:0] mw_pc_new_o,
    output logic        mw_fault_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [0:0]  state;
    logic [7:0]  wait_cnt;

    logic        access;
    logic        is_read;
    logic        f3_illegal;
    logic        misaligned;
    logic        bad_access;
    logic        start_access;
    logic        ack_seen;
    logic        timed_out;
    logic        capture;
    logic        fault_nxt;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    always_comb begin
        access  = em_mem_read_i | em_mem_write_i;
        is_read = em_mem_read_i;

        case (em_funct3_i)
            3'b000, 3'b001, 3'b010: f3_illegal = 1'b0;
            3'b100, 3'b101:         f3_illegal = ~is_read;
            default:                f3_illegal = 1'b1;
        endcase

        case (em_funct3_i[1:0])
            2'b01:   misaligned = em_alu_result_i[0];
            2'b10:   misaligned = (em_alu_result_i[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        bad_access = f3_illegal | misaligned;

        case (em_funct3_i[1:0])
            2'b00:   be_nxt = 4'b0001 << em_alu_result_i[1:0];
            2'b01:   be_nxt = em_alu_result_i[1] ? 4'b1100 : 4'b0011;
            default: be_nxt = 4'b1111;
        endcase

        if (is_read) begin
            wdata_nxt = 32'h0;
        end else begin
            case (em_funct3_i[1:0])
                2'b00:   wdata_nxt = {4{em_read_data2_i[7:0]}};
                2'b01:   wdata_nxt = {2{em_read_data2_i[15:0]}};
                default: wdata_nxt = em_read_data2_i;
            endcase
        end

        case (em_alu_result_i[1:0])
            2'b00:   byte_sel = dmem_rdata_i[7:0];
            2'b01:   byte_sel = dmem_rdata_i[15:8];
            2'b10:   byte_sel = dmem_rdata_i[23:16];
            default: byte_sel = dmem_rdata_i[31:24];
        endcase
        half_sel = em_alu_result_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

        case (em_funct3_i)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_fmt = {24'h0, byte_sel};
            3'b101:  load_fmt = {16'h0, half_sel};
            default: load_fmt = dmem_rdata_i;
        endcase

        start_access = (state == ST_IDLE) & access & ~bad_access;
        ack_seen     = (state == ST_BUSY) & dmem_ack_i;
        timed_out    = (state == ST_BUSY) & ~dmem_ack_i & (wait_cnt == WAIT_LAST);
        // Every cycle that is not a bubble updates the mw register.
        capture      = ((state == ST_IDLE) & ~start_access) | ack_seen | timed_out;
        fault_nxt    = ((state == ST_IDLE) & access & bad_access) | timed_out;
        mem_stall_o  = start_access | ((state == ST_BUSY) & ~dmem_ack_i & ~timed_out);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state               <= ST_IDLE;
            wait_cnt            <= 8'h0;
            dmem_req_o          <= 1'b0;
            dmem_we_o           <= 1'b0;
            dmem_addr_o         <= 32'h0;
            dmem_be_o           <= 4'h0;
            dmem_wdata_o        <= 32'h0;
            mw_reg_write_o      <= 1'b0;
            mw_dmem_to_reg_o    <= 2'b00;
            mw_write_addr_reg_o <= 5'h0;
            mw_alu_result_o     <= 32'h0;
            mw_load_data_o      <= 32'h0;
            mw_pc_new_o         <= 32'h0;
            mw_fault_o          <= 1'b0;
        end else begin
            mw_fault_o     <= fault_nxt;
            mw_reg_write_o <= capture & ~fault_nxt & em_reg_write_i;

            if (capture) begin
                mw_dmem_to_reg_o    <= em_dmem_to_reg_i;
                mw_write_addr_reg_o <= em_write_addr_reg_i;
                mw_alu_result_o     <= em_alu_result_i;
                mw_pc_new_o         <= em_pc_new_i;
                mw_load_data_o      <= (ack_seen & is_read) ? load_fmt : 32'h0;
            end

            case (state)
                ST_IDLE: begin
                    if (start_access) begin
                        state        <= ST_BUSY;
                        wait_cnt     <= 8'h0;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= ~is_read;
                        dmem_addr_o  <= {em_alu_result_i[31:2], 2'b00};
                        dmem_be_o    <= be_nxt;
                        dmem_wdata_o <= wdata_nxt;
                    end
                end
                ST_BUSY: begin
                    if (ack_seen || timed_out) begin
                        state      <= ST_IDLE;
                        dmem_req_o <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage: each operation is predicted from an
// arithmetic transaction model and checked cycle by cycle against the DUT.
module tb_memory_access_stage;

    localparam int T = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        em_reg_write_i, em_mem_read_i, em_mem_write_i;
    logic [1:0]  em_dmem_to_reg_i;
    logic [2:0]  em_funct3_i;
    logic [4:0]  em_write_addr_reg_i;
    logic [31:0] em_alu_result_i, em_read_data2_i, em_pc_new_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        mem_stall_o, mw_reg_write_o, mw_fault_o;
    logic [1:0]  mw_dmem_to_reg_o;
    logic [4:0]  mw_write_addr_reg_o;
    logic [31:0] mw_alu_result_o, mw_load_data_o, mw_pc_new_o;

    int n_vec = 0;
    int n_err = 0;

    memory_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .em_reg_write_i(em_reg_write_i), .em_mem_read_i(em_mem_read_i),
        .em_mem_write_i(em_mem_write_i), .em_dmem_to_reg_i(em_dmem_to_reg_i),
        .em_funct3_i(em_funct3_i), .em_write_addr_reg_i(em_write_addr_reg_i),
        .em_alu_result_i(em_alu_result_i), .em_read_data2_i(em_read_data2_i),
        .em_pc_new_i(em_pc_new_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .mem_stall_o(mem_stall_o), .mw_reg_write_o(mw_reg_write_o),
        .mw_dmem_to_reg_o(mw_dmem_to_reg_o), .mw_write_addr_reg_o(mw_write_addr_reg_o),
        .mw_alu_result_o(mw_alu_result_o), .mw_load_data_o(mw_load_data_o),
        .mw_pc_new_o(mw_pc_new_o), .mw_fault_o(mw_fault_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_mw(input logic rw, input logic [1:0] d2r, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] pc,
                          input logic [31:0] ld, input logic flt);
        chk("mw_reg_write", 32'(mw_reg_write_o), 32'(rw));
        chk("mw_dmem_to_reg", 32'(mw_dmem_to_reg_o), 32'(d2r));
        chk("mw_rd", 32'(mw_write_addr_reg_o), 32'(rd));
        chk("mw_alu", mw_alu_result_o, a);
        chk("mw_pc", mw_pc_new_o, pc);
        chk("mw_load", mw_load_data_o, ld);
        chk("mw_fault", 32'(mw_fault_o), 32'(flt));
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic do_op(input logic rd_en, input logic wr_en, input logic rw,
                         input logic [1:0] d2r, input logic [2:0] f3, input logic [4:0] rdst,
                         input logic [31:0] a, input logic [31:0] d2, input logic [31:0] pc,
                         input logic [31:0] rdata, input int ack_dly);
        bit          access, legal_f3, bad;
        int          nbytes, off;
        logic [31:0] exp_be, exp_wd, exp_ld, mask;
        bit          ack;

        access   = rd_en || wr_en;
        legal_f3 = (f3 <= 3'd2) || (rd_en && (f3 == 3'd4 || f3 == 3'd5));
        nbytes   = 1 << f3[1:0];
        off      = int'(a % 4);
        bad      = !legal_f3 || (legal_f3 && (off % nbytes) != 0);
        exp_be   = ((32'd1 << nbytes) - 1) << off;
        mask     = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 1);
        exp_wd   = rd_en ? 32'h0 : (nbytes == 1) ? (d2 & mask) * 32'h0101_0101 :
                   (nbytes == 2) ? (d2 & mask) * 32'h0001_0001 : d2;
        exp_ld   = (rdata >> (8 * off)) & mask;
        if (!f3[2] && nbytes < 4 && exp_ld[8 * nbytes - 1])
            exp_ld = exp_ld - (32'd1 << (8 * nbytes));

        em_mem_read_i = rd_en;  em_mem_write_i = wr_en;  em_reg_write_i = rw;
        em_dmem_to_reg_i = d2r; em_funct3_i = f3;        em_write_addr_reg_i = rdst;
        em_alu_result_i = a;    em_read_data2_i = d2;    em_pc_new_i = pc;
        dmem_ack_i = access ? 1'b0 : 1'($urandom_range(0, 1));
        dmem_rdata_i = $urandom;
        #1;
        chk("stall_idle", 32'(mem_stall_o), 32'(access && !bad));
        chk("req_idle", 32'(dmem_req_o), 32'd0);
        @(posedge clk_i); #1;
        if (!access || bad) begin
            chk_mw(rw && !access, d2r, rdst, a, pc, 32'h0, access);
        end else begin
            chk("bubble_rw", 32'(mw_reg_write_o), 32'd0);
            chk("bubble_fault", 32'(mw_fault_o), 32'd0);
            for (int k = 0; k < T; k++) begin
                @(negedge clk_i);
                ack = (k == ack_dly);
                dmem_ack_i = ack;
                dmem_rdata_i = ack ? rdata : $urandom;
                #1;
                chk("req_busy", 32'(dmem_req_o), 32'd1);
                chk("we", 32'(dmem_we_o), 32'(wr_en && !rd_en));
                chk("addr", dmem_addr_o, a & 32'hFFFF_FFFC);
                chk("be", 32'(dmem_be_o), exp_be);
                chk("wdata", dmem_wdata_o, exp_wd);
                chk("stall_busy", 32'(mem_stall_o), 32'(!ack && k != T - 1));
                @(posedge clk_i); #1;
                if (ack) begin
                    chk_mw(rw, d2r, rdst, a, pc, rd_en ? exp_ld : 32'h0, 1'b0);
                    chk("req_drop", 32'(dmem_req_o), 32'd0);
                    break;
                end else if (k == T - 1) begin
                    chk("timeout_fault", 32'(mw_fault_o), 32'd1);
                    chk("timeout_rw", 32'(mw_reg_write_o), 32'd0);
                    chk("timeout_req", 32'(dmem_req_o), 32'd0);
                end else begin
                    chk("wait_rw", 32'(mw_reg_write_o), 32'd0);
                end
            end
        end
        @(negedge clk_i);
        dmem_ack_i = 1'b0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          kind;

        reset_i = 1'b1;
        em_reg_write_i = 0; em_mem_read_i = 0; em_mem_write_i = 0; em_dmem_to_reg_i = 0;
        em_funct3_i = 0; em_write_addr_reg_i = 0; em_alu_result_i = 0; em_read_data2_i = 0;
        em_pc_new_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_stall", 32'(mem_stall_o), 32'd0);
        chk("rst_be", 32'(dmem_be_o), 32'd0);
        chk_mw(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk_i);
        reset_i = 1'b0;

        do_op(0, 0, 1, 2'b00, 3'd0, 5'd5, 32'h42, 32'h0, 32'h100, 32'h0, 0);
        do_op(0, 0, 1, 2'b10, 3'd0, 5'd1, 32'h0, 32'h0, 32'h104, 32'h0, 0);
        do_op(1, 0, 1, 2'b01, 3'd2, 5'd7, 32'h1000, 32'h0, 32'h0, 32'hDEADBEEF, 3);
        do_op(1, 0, 1, 2'b01, 3'd0, 5'd8, 32'h1003, 32'h0, 32'h0, 32'h80FF_FF7F, 1);
        do_op(1, 0, 1, 2'b01, 3'd4, 5'd9, 32'h1003, 32'h0, 32'h0, 32'h80FF_FF7F, 0);
        do_op(1, 0, 1, 2'b01, 3'd5, 5'd10, 32'h1002, 32'h0, 32'h0, 32'h80FF_FF7F, 2);
        do_op(0, 1, 0, 2'b00, 3'd1, 5'd0, 32'h2002, 32'h1234_ABCD, 32'h0, 32'h0, 0);
        do_op(1, 0, 1, 2'b01, 3'd2, 5'd3, 32'h1002, 32'h0, 32'h0, 32'h0, 0);
        do_op(0, 1, 0, 2'b00, 3'd4, 5'd0, 32'h3000, 32'h55, 32'h0, 32'h0, 0);
        do_op(1, 0, 1, 2'b01, 3'd2, 5'd4, 32'h1008, 32'h0, 32'h0, 32'h0, 99);
        do_op(0, 0, 1, 2'b00, 3'd0, 5'd6, 32'h77, 32'h0, 32'h8, 32'h0, 0);

        // Reset while BUSY must discard the access.
        em_mem_read_i = 1; em_mem_write_i = 0; em_funct3_i = 3'd2;
        em_alu_result_i = 32'h4000; em_reg_write_i = 1; em_write_addr_reg_i = 5'd2;
        @(posedge clk_i); @(negedge clk_i);
        chk("pre_rst_req", 32'(dmem_req_o), 32'd1);
        reset_i = 1'b1; em_mem_read_i = 0;
        @(posedge clk_i); #1;
        chk("midrst_req", 32'(dmem_req_o), 32'd0);
        chk("midrst_stall", 32'(mem_stall_o), 32'd0);
        chk_mw(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk_i);
        reset_i = 1'b0;
        do_op(0, 0, 1, 2'b00, 3'd0, 5'd11, 32'h99, 32'h0, 32'hC, 32'h0, 0);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 5);
            f3 = (kind == 5) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            if (kind == 2 && $urandom_range(0, 1) == 1) f3 = f3 | 3'b100;
            if (f3 == 3'd6) f3 = 3'd4;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 1);
            do_op(kind == 2 || kind == 4 || (kind == 5 && a[5]), kind == 3 || kind == 4 || kind == 5,
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), f3,
                  5'($urandom), a, $urandom, $urandom, $urandom, $urandom_range(0, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Memory stage of the 5-stage pipeline. It sits between the execute/memory pipeline register and the writeback stage.
- Consumes the execute/memory register outputs and runs load/store accesses on a req/ack data-memory bus. Handles byte-lane alignment, load extension, stall generation and timeout/misalignment faults.
- Registers the results as the memory/writeback pipeline register.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles without dmem_ack_i before the access aborts (1..255, 8-bit counter).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- reset_i  input  1  reset, synchronous, active-high
- em_reg_write_i  input  1  register-file write enable from execute/memory register
- em_mem_read_i  input  1  load
- em_mem_write_i  input  1  store
- em_dmem_to_reg_i  input  2  writeback select: 00 ALU, 01 load data, 10 pc_new
- em_funct3_i  input  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store uses 000/001/010
- em_write_addr_reg_i  input  5  destination register
- em_alu_result_i  input  32  effective address / ALU result
- em_read_data2_i  input  32  store data
- em_pc_new_i  input  32  link value (PC+4)
- dmem_req_o  output  1  bus request, held until ack
- dmem_we_o  output  1  1 = write
- dmem_addr_o  output  32  word address: {addr[31:2],2'b00}
- dmem_be_o  output  4  byte enables
- dmem_wdata_o  output  32  lane-replicated store data
- dmem_ack_i  input  1  access complete; rdata valid in the same cycle
- dmem_rdata_i  input  32  read word
- mem_stall_o  output  1  combinational; upstream holds the execute/memory register while high
- mw_reg_write_o  output  1  writeback enable
- mw_dmem_to_reg_o  output  2  registered select
- mw_write_addr_reg_o  output  5  registered destination
- mw_alu_result_o  output  32  registered ALU result
- mw_load_data_o  output  32  extended load value
- mw_pc_new_o  output  32  registered link value
- mw_fault_o  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Reset: state IDLE, timeout counter 0, every output 0 (dmem_* and mw_*); mem_stall_o = 0.
- Access condition: access = em_mem_read_i | em_mem_write_i. If both are high, treated as a read.
- Legality checks:
  - Illegal funct3: 011, 110, 111; also 100/101 on a store.
  - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
- IDLE, no access: the memory/writeback register captures the inputs every cycle (latency 1). mw_load_data_o = 0.
- IDLE, illegal or misaligned access:
  - No bus request; mem_stall_o = 0.
  - Next edge: mw_fault_o = 1, mw_reg_write_o = 0, other mw_* captured.
- IDLE, legal access:
  - mem_stall_o = 1 this cycle; mw_reg_write_o <= 0 (bubble).
  - Next edge: go to BUSY, assert dmem_req_o, drive dmem_we_o, addr, be and wdata from the held inputs; counter <= 0.
- BUSY:
  - dmem_* outputs are stable while waiting.
  - mem_stall_o = ~dmem_ack_i; each cycle without ack inserts a bubble and increments the counter.
- BUSY, ack seen:
  - mem_stall_o = 0.
  - At the edge: capture mw_* including the formatted load data; mw_reg_write_o = em_reg_write_i; dmem_req_o <= 0; go to IDLE.
  - Minimum load/store occupancy: 2 cycles.
- BUSY, timeout: counter reaches TIMEOUT_CYCLES-1 with no ack.
  - mem_stall_o = 0 that cycle.
  - Next edge: req drops, IDLE, mw_fault_o = 1, mw_reg_write_o = 0.
  - A late ack in IDLE is ignored.
- Store lanes:
  - SB: wdata = {4{d[7:0]}}, be = 0001 << addr[1:0].
  - SH: wdata = {2{d[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: wdata = d, be = 1111.
- Load lanes: dmem_be_o follows the same rule as stores; dmem_wdata_o = 0.
  - LB/LBU select byte addr[1:0].
  - LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Reset mid-access: at the reset edge req drops, the state returns to IDLE and the pending access is discarded.
- dmem_ack_i outside BUSY is ignored.

Test Plan:
- ALU op add, result 0x0000_0042, rd=5, back-to-back with a link op (dmem_to_reg=10, pc_new 0x104) -> one cycle each: mw_alu_result_o=0x42, mw_reg_write_o=1; next cycle mw_pc_new_o=0x104; mem_stall_o never high.
- LW addr 0x1000, ack after 3 wait cycles, rdata 0xDEADBEEF -> dmem_req_o high 4 cycles, addr 0x1000, be 1111; stall high 4 cycles; mw_load_data_o=0xDEADBEEF, mw_reg_write_o=1 once.
- LB addr 0x1003, rdata 0x80FF_FF7F -> 0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr 0x1002 -> 0x0000_80FF.
- SH addr 0x2002, data 0x1234_ABCD, immediate ack -> we=1, addr 0x2000, be 1100, wdata 0xABCD_ABCD; mw_reg_write_o=0.
- LW addr 0x1002 -> no dmem_req_o, no stall, mw_fault_o pulses 1 cycle, mw_reg_write_o=0.
- Load with no ack (TIMEOUT_CYCLES=4) -> req high exactly 4 cycles, then mw_fault_o pulse. Separately, reset asserted in BUSY -> req and all mw_* zero after that edge, state IDLE.
